pipe_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. It collects hazard stall requests (multiplier RAW from `stall_ctrl_mult`, load-use, external memory wait), EX-stage jumps and multiplier fence requests. It drives per-stage hold and flush controls to `pc_gen`, `IF_ID`, `ID_EX`, `EX_MEM` and `MEM_WB`. A small FSM covers multi-cycle flush after a jump (synchronous instruction memory), full-pipeline freeze with a deferred jump, and multiplier-pipeline drain.

---
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: arbitrates freeze, jump flush,
// multiplier fence and ID-stage hazards into per-stage hold/bubble controls.
`ifndef MULT_PPL_STAGE
`define MULT_PPL_STAGE 3
`endif

module pipe_ctrl #(
    parameter int MULT_PPL_STAGE = `MULT_PPL_STAGE,
    parameter int FLUSH_CYCLES   = 2,
    parameter int STALL_TIMEOUT  = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_req_mult,
    input  logic                      stall_req_load,
    input  logic                      ext_stall,
    input  logic                      pc_jump,
    input  logic                      fence_req,
    input  logic [MULT_PPL_STAGE-1:0] mult_uses,
    output logic [4:0]                stall,
    output logic [3:0]                flush,
    output logic                      jump_go,
    output logic                      fence_ack,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [1:0]                state_dbg
);

    localparam int FCW = $clog2(FLUSH_CYCLES + 1);
    localparam int SCW = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_FREEZE, S_FENCE} state_t;

    state_t           state, state_nx, ret_state, ret_nx, eff_state;
    logic [FCW-1:0]   flush_cnt, flush_cnt_nx;
    logic             jump_pend, jump_pend_nx;
    logic [SCW-1:0]   stall_cnt;
    logic             jump_req;
    logic             mult_busy;

    // FREEZE resumes as the interrupted state, so all decisions use eff_state.
    assign eff_state = (state == S_FREEZE) ? ret_state : state;
    assign jump_req  = pc_jump | jump_pend;
    assign mult_busy = |mult_uses;
    assign busy      = (state != S_RUN);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_RUN;
            ret_state   <= S_RUN;
            flush_cnt   <= '0;
            jump_pend   <= 1'b0;
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_nx;
            ret_state <= ret_nx;
            flush_cnt <= flush_cnt_nx;
            jump_pend <= jump_pend_nx;
            if (!stall[0])
                stall_cnt <= '0;
            else if (stall_cnt != SCW'(STALL_TIMEOUT))
                stall_cnt <= stall_cnt + SCW'(1);
            if (stall[0] && (stall_cnt == SCW'(STALL_TIMEOUT - 1)))
                timeout_err <= 1'b1;
        end
    end

    always_comb begin
        state_nx     = state;
        ret_nx       = ret_state;
        flush_cnt_nx = flush_cnt;
        jump_pend_nx = jump_pend;
        if (ext_stall) begin
            if (state != S_FREEZE)
                ret_nx = state;
            state_nx = S_FREEZE;
            if (pc_jump)
                jump_pend_nx = 1'b1;
        end else if (jump_req) begin
            jump_pend_nx = 1'b0;
            if (FLUSH_CYCLES > 1) begin
                state_nx     = S_FLUSH;
                flush_cnt_nx = FCW'(FLUSH_CYCLES - 1);
            end else begin
                state_nx = S_RUN;
            end
        end else begin
            state_nx = eff_state;
            case (eff_state)
                S_FLUSH: begin
                    flush_cnt_nx = flush_cnt - FCW'(1);
                    if (flush_cnt <= FCW'(1))
                        state_nx = S_RUN;
                end
                S_FENCE: state_nx = mult_busy ? S_FENCE : S_RUN;
                S_RUN:   if (fence_req && mult_busy) state_nx = S_FENCE;
                default: state_nx = S_RUN;
            endcase
        end
    end

    // fence_req is a level request held by the requester until the one-cycle fence_ack.
    always_comb begin
        stall     = 5'b00000;
        flush     = 4'b0000;
        jump_go   = 1'b0;
        fence_ack = 1'b0;
        if (!rst) begin
            flush = 4'b1111;
        end else if (ext_stall) begin
            stall = 5'b11111;
        end else if (jump_req) begin
            jump_go = 1'b1;
            flush   = 4'b0011;
        end else begin
            case (eff_state)
                S_FLUSH: flush = 4'b0001;
                S_FENCE: begin
                    if (mult_busy) begin
                        stall = 5'b00011;
                        flush = 4'b0010;
                    end else begin
                        fence_ack = 1'b1;
                    end
                end
                S_RUN: begin
                    if (fence_req) begin
                        if (mult_busy) begin
                            stall = 5'b00011;
                            flush = 4'b0010;
                        end else begin
                            fence_ack = 1'b1;
                        end
                    end else if (stall_req_mult || stall_req_load) begin
                        stall = 5'b00011;
                        flush = 4'b0010;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan scenarios with literal
// expectations, then randomized traffic compared every cycle against a behavioural model.
module tb_pipe_ctrl;

    localparam int FC = 2;
    localparam int ST = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stall_req_mult = 1'b0, stall_req_load = 1'b0, ext_stall = 1'b0;
    logic       pc_jump = 1'b0, fence_req = 1'b0;
    logic [2:0] mult_uses = 3'b000;
    logic [4:0] stall;
    logic [3:0] flush;
    logic       jump_go, fence_ack, busy, timeout_err;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model: remaining IF_ID flush cycles, fence in progress, frozen, deferred jump
    int   m_flush_left, n_flush_left;
    bit   m_fencing, n_fencing, m_frozen, n_frozen, m_pend, n_pend, m_to, n_to;
    int   m_consec, n_consec;
    logic [4:0] e_stall;
    logic [3:0] e_flush;
    logic       e_jg, e_ack, e_busy, e_to;

    pipe_ctrl #(.MULT_PPL_STAGE(3), .FLUSH_CYCLES(FC), .STALL_TIMEOUT(ST)) dut (
        .clk(clk), .rst(rst),
        .stall_req_mult(stall_req_mult), .stall_req_load(stall_req_load),
        .ext_stall(ext_stall), .pc_jump(pc_jump), .fence_req(fence_req),
        .mult_uses(mult_uses),
        .stall(stall), .flush(flush), .jump_go(jump_go), .fence_ack(fence_ack),
        .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        if (!rst) begin
            m_flush_left = 0; m_fencing = 0; m_frozen = 0; m_pend = 0; m_to = 0; m_consec = 0;
        end
        n_flush_left = m_flush_left; n_fencing = m_fencing; n_frozen = m_frozen;
        n_pend = m_pend; n_to = m_to; n_consec = m_consec;
        e_stall = 5'b0; e_flush = 4'b0; e_jg = 0; e_ack = 0;
        if (!rst) begin
            e_flush = 4'b1111;
        end else if (ext_stall) begin
            e_stall = 5'b11111;
            n_frozen = 1;
            if (pc_jump) n_pend = 1;
        end else begin
            n_frozen = 0;
            if (pc_jump || m_pend) begin
                e_jg = 1; e_flush = 4'b0011;
                n_pend = 0; n_flush_left = FC - 1; n_fencing = 0;
            end else if (m_flush_left > 0) begin
                e_flush = 4'b0001;
                n_flush_left = m_flush_left - 1;
            end else if (m_fencing || fence_req) begin
                if (mult_uses != 0) begin
                    e_stall = 5'b00011; e_flush = 4'b0010; n_fencing = 1;
                end else begin
                    e_ack = 1; n_fencing = 0;
                end
            end else if (stall_req_mult || stall_req_load) begin
                e_stall = 5'b00011; e_flush = 4'b0010;
            end
        end
        e_busy = rst && (m_frozen || m_flush_left > 0 || m_fencing);
        e_to = m_to;
        if (rst) begin
            if (e_stall[0]) begin
                if (m_consec == ST - 1) n_to = 1;
                n_consec = m_consec + 1;
            end else begin
                n_consec = 0;
            end
        end
        cmp("stall", {3'b0, stall}, {3'b0, e_stall});
        cmp("flush", {4'b0, flush}, {4'b0, e_flush});
        cmp("jump_go", {7'b0, jump_go}, {7'b0, e_jg});
        cmp("fence_ack", {7'b0, fence_ack}, {7'b0, e_ack});
        cmp("busy", {7'b0, busy}, {7'b0, e_busy});
        cmp("timeout_err", {7'b0, timeout_err}, {7'b0, e_to});
    endtask

    task automatic apply(input logic sm, input logic sl, input logic es, input logic pj,
                         input logic fr, input logic [2:0] mu);
        stall_req_mult = sm; stall_req_load = sl; ext_stall = es;
        pc_jump = pj; fence_req = fr; mult_uses = mu;
        #3;
        model_check();
    endtask

    task automatic adv();
        m_flush_left = n_flush_left; m_fencing = n_fencing; m_frozen = n_frozen;
        m_pend = n_pend; m_to = n_to; m_consec = n_consec;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic fr_hold;
        fr_hold = 0;
        m_flush_left = 0; m_fencing = 0; m_frozen = 0; m_pend = 0; m_to = 0; m_consec = 0;
        #1;
        apply(0, 0, 0, 0, 0, 3'b000);
        cmp("rst_flush", {4'b0, flush}, 8'h0f);
        cmp("rst_busy", {7'b0, busy}, 8'h00);
        adv();
        rst = 1'b1;

        // load-use
        apply(0, 1, 0, 0, 0, 3'b000);
        cmp("ld_stall", {3'b0, stall}, 8'h03);
        cmp("ld_flush", {4'b0, flush}, 8'h02);
        adv();
        apply(0, 0, 0, 0, 0, 3'b000);
        cmp("ld_after_stall", {3'b0, stall}, 8'h00);
        cmp("ld_after_busy", {7'b0, busy}, 8'h00);
        adv();

        // jump with hazard ignored during FLUSH
        apply(0, 0, 0, 1, 0, 3'b000);
        cmp("jmp_go", {7'b0, jump_go}, 8'h01);
        cmp("jmp_flush", {4'b0, flush}, 8'h03);
        adv();
        apply(1, 0, 0, 0, 0, 3'b000);
        cmp("jmp_t1_flush", {4'b0, flush}, 8'h01);
        cmp("jmp_t1_busy", {7'b0, busy}, 8'h01);
        cmp("jmp_t1_stall", {3'b0, stall}, 8'h00);
        adv();
        apply(0, 0, 0, 0, 0, 3'b000);
        cmp("jmp_t2_flush", {4'b0, flush}, 8'h00);
        cmp("jmp_t2_busy", {7'b0, busy}, 8'h00);
        adv();

        // deferred jump under ext_stall
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, (i == 0), 0, 3'b000);
            cmp("frz_stall", {3'b0, stall}, 8'h1f);
            cmp("frz_jump_go", {7'b0, jump_go}, 8'h00);
            adv();
        end
        apply(0, 0, 0, 0, 0, 3'b000);
        cmp("dfr_jump_go", {7'b0, jump_go}, 8'h01);
        cmp("dfr_flush", {4'b0, flush}, 8'h03);
        adv();
        apply(0, 0, 0, 0, 0, 3'b000);
        cmp("dfr_t4_flush", {4'b0, flush}, 8'h01);
        adv();
        apply(0, 0, 0, 0, 0, 3'b000);
        adv();

        // fence drain
        apply(0, 0, 0, 0, 1, 3'b110);
        cmp("fnc_t0_stall", {3'b0, stall}, 8'h03);
        cmp("fnc_t0_flush", {4'b0, flush}, 8'h02);
        adv();
        apply(0, 0, 0, 0, 1, 3'b011);
        cmp("fnc_t1_stall", {3'b0, stall}, 8'h03);
        adv();
        apply(0, 0, 0, 0, 1, 3'b001);
        cmp("fnc_t2_flush", {4'b0, flush}, 8'h02);
        adv();
        apply(0, 0, 0, 0, 1, 3'b000);
        cmp("fnc_t3_ack", {7'b0, fence_ack}, 8'h01);
        cmp("fnc_t3_stall", {3'b0, stall}, 8'h00);
        adv();
        apply(0, 0, 0, 0, 0, 3'b000);
        cmp("fnc_t4_busy", {7'b0, busy}, 8'h00);
        adv();
        apply(0, 0, 0, 0, 1, 3'b000);
        cmp("fnc0_ack", {7'b0, fence_ack}, 8'h01);
        cmp("fnc0_stall", {3'b0, stall}, 8'h00);
        adv();
        apply(0, 0, 0, 0, 0, 3'b000);
        adv();

        // stall timeout
        for (int i = 0; i < 6; i++) begin
            apply(1, 0, 0, 0, 0, 3'b000);
            cmp("to_hold", {7'b0, timeout_err}, (i >= 4) ? 8'h01 : 8'h00);
            adv();
        end
        apply(0, 0, 0, 0, 0, 3'b000);
        cmp("to_sticky", {7'b0, timeout_err}, 8'h01);
        adv();
        rst = 1'b0;
        apply(0, 0, 0, 0, 0, 3'b000);
        cmp("to_cleared", {7'b0, timeout_err}, 8'h00);
        adv();
        rst = 1'b1;

        // reset mid-FLUSH
        apply(0, 0, 0, 1, 0, 3'b000);
        cmp("rmf_go", {7'b0, jump_go}, 8'h01);
        adv();
        rst = 1'b0;
        apply(0, 0, 0, 0, 0, 3'b000);
        cmp("rmf_flush", {4'b0, flush}, 8'h0f);
        cmp("rmf_busy", {7'b0, busy}, 8'h00);
        adv();
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 3'b000);
        cmp("rmf_rel_flush", {4'b0, flush}, 8'h00);
        cmp("rmf_rel_busy", {7'b0, busy}, 8'h00);
        adv();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] mu;
            rst = ($urandom_range(0, 199) != 0);
            if (!fr_hold && $urandom_range(0, 9) == 0) fr_hold = 1;
            mu = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            apply(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0), fr_hold, mu);
            if (e_ack) fr_hold = 0;
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
